// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared types and defaults for the CPU/DMA memory arbiter
package mem_bus_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH     = 16;
  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_MAX_BURST      = 8;
  localparam int DEF_CPU_MIN_CYCLES = 4;

  typedef enum logic [1:0] {
    S_CPU     = 2'd0,
    S_DMA     = 2'd1,
    S_RESTORE = 2'd2
  } arb_state_e;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one sync-read memory between the 6502 core and a DMA requester
// The CPU is stalled via cpu_ready while DMA owns the port; its held address is re-read before release.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int MAX_BURST      = DEF_MAX_BURST,
  parameter int CPU_MIN_CYCLES = DEF_CPU_MIN_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_address_next,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic                  cpu_write,
  input  logic [DATA_WIDTH-1:0] cpu_data_o,
  output logic                  cpu_ready,
  input  logic                  dma_req,
  input  logic                  dma_write,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_ack,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_rvalid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr_r,
  output logic [ADDR_WIDTH-1:0] mem_addr_w,
  output logic [DATA_WIDTH-1:0] mem_di,
  input  logic [DATA_WIDTH-1:0] mem_do
);

  localparam int BURST_W = cnt_width(MAX_BURST);
  localparam int COOL_W  = cnt_width(CPU_MIN_CYCLES);

  arb_state_e         state;
  arb_state_e         next_state;
  logic [BURST_W-1:0] burst;
  logic [COOL_W-1:0]  cooldown;
  logic               last_beat;

  assign last_beat = (burst == BURST_W'(MAX_BURST - 1));
  assign dma_rdata = mem_do;

  always_comb begin
    next_state = state;
    case (state)
      S_CPU:     if (dma_req && (cooldown == '0)) next_state = S_DMA;
      S_DMA:     if (!dma_req || last_beat) next_state = S_RESTORE;
      S_RESTORE: next_state = S_CPU;
      default:   next_state = S_CPU;
    endcase
  end

  // Port steering; reset gates every strobe so a burst cut by reset leaves no partial write.
  always_comb begin
    dma_ack    = 1'b0;
    mem_we     = 1'b0;
    mem_addr_r = cpu_address_next;
    mem_addr_w = cpu_address;
    mem_di     = cpu_data_o;
    case (state)
      S_CPU: mem_we = cpu_write;
      S_DMA: begin
        dma_ack    = dma_req;
        mem_we     = dma_req & dma_write;
        mem_addr_r = dma_addr;
        mem_addr_w = dma_addr;
        mem_di     = dma_wdata;
      end
      S_RESTORE: mem_addr_r = cpu_address;
      default: ;
    endcase
    if (reset) begin
      dma_ack = 1'b0;
      mem_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_CPU;
      cpu_ready  <= 1'b1;
      dma_rvalid <= 1'b0;
      burst      <= '0;
      cooldown   <= '0;
    end else begin
      state      <= next_state;
      cpu_ready  <= (next_state == S_CPU);
      dma_rvalid <= dma_ack & ~dma_write;
      case (state)
        S_CPU: if (cooldown != '0) cooldown <= cooldown - COOL_W'(1);
        S_DMA: if (dma_ack) burst <= burst + BURST_W'(1);
        S_RESTORE: begin
          burst    <= '0;
          cooldown <= COOL_W'(CPU_MIN_CYCLES);
        end
        default: ;
      endcase
    end
  end

endmodule
